// File: rtl/pb_input_cond_if.sv
// Push-button / switch conditioning bundle.
// Raw pins come in; clean levels, press pulses and mode go out.
interface pb_input_cond_if #(
  parameter int N_BTN = 4,
  parameter int N_SW  = 2
);
  logic [N_BTN-1:0] btn;
  logic [N_SW-1:0]  sw;
  logic [N_BTN-1:0] btn_db;
  logic [N_SW-1:0]  sw_db;
  logic [N_BTN-1:0] btn_press;
  logic [1:0]       mode;
  logic             mode_valid;

  modport master (
    output btn, sw,
    input  btn_db, sw_db, btn_press, mode, mode_valid
  );

  modport slave (
    input  btn, sw,
    output btn_db, sw_db, btn_press, mode, mode_valid
  );
endinterface

// File: rtl/pb_input_cond.sv
// Button/switch front end: 2-flop sync, per-bit debounce,
// press pulse generation and priority mode encoder.
module pb_input_cond #(
  parameter int N_BTN           = 4,
  parameter int N_SW            = 2,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 21
) (
  input  logic                 clk_125,
  input  logic                 sys_rst,
  pb_input_cond_if.slave       pb
);

  localparam int N = N_BTN + N_SW;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     raw;
  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [N-1:0]     stable;
  logic [N-1:0]     rise;
  logic [CNT_W-1:0] cnt [N];
  logic [N_BTN-1:0] press_q;
  logic [1:0]       mode_q;
  logic             valid_q;

  assign raw = {pb.sw, pb.btn};

  // Two-flop synchroniser for every raw pin
  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A bit is about to be accepted high on this edge
  always_comb begin
    rise = '0;
    for (int i = 0; i < N; i++) begin
      rise[i] = s2[i] & ~stable[i] & (cnt[i] == LAST);
    end
  end

  // Per-bit debounce: new level must hold DEBOUNCE_CYCLES
  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      stable <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Press pulse aligned with the first high cycle of btn_db
  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      press_q <= '0;
    end else begin
      press_q <= rise[N_BTN-1:0];
    end
  end

  // Priority encode presses into mode, strobe on every press
  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      mode_q  <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= |press_q;
      priority case (1'b1)
        press_q[3]: mode_q <= 2'd3;
        press_q[2]: mode_q <= 2'd2;
        press_q[1]: mode_q <= 2'd1;
        press_q[0]: mode_q <= 2'd0;
        default:    mode_q <= mode_q;
      endcase
    end
  end

  assign pb.btn_db     = stable[N_BTN-1:0];
  assign pb.sw_db      = stable[N-1:N_BTN];
  assign pb.btn_press  = press_q;
  assign pb.mode       = mode_q;
  assign pb.mode_valid = valid_q;

endmodule

// File: tb/tb_pb_input_cond.sv
// Directed bench for pb_input_cond with DEBOUNCE_CYCLES=4.
// Edge 0 is the first posedge after an input change.
module tb_pb_input_cond;

  logic clk_125 = 1'b0;
  logic sys_rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  pb_input_cond_if #(.N_BTN(4), .N_SW(2)) pb_if ();

  pb_input_cond #(
    .N_BTN(4),
    .N_SW(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
  ) dut (
    .clk_125(clk_125),
    .sys_rst(sys_rst),
    .pb(pb_if.slave)
  );

  always #4 clk_125 = ~clk_125;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_125);
    #1;
  endtask

  initial begin
    sys_rst   = 1'b1;
    pb_if.btn = 4'b0000;
    pb_if.sw  = 2'b00;
    tick(1);

    // 1. reset with everything held high
    pb_if.btn = 4'b1111;
    pb_if.sw  = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst_btn_db", pb_if.btn_db, 0);
      check("rst_sw_db", pb_if.sw_db, 0);
      check("rst_press", pb_if.btn_press, 0);
      check("rst_mode", pb_if.mode, 0);
      check("rst_valid", pb_if.mode_valid, 0);
    end
    sys_rst = 1'b0;
    tick(5);
    check("t1_db_e4", pb_if.btn_db, 4'h0);
    tick(1);
    check("t1_db_e5", pb_if.btn_db, 4'hf);
    check("t1_sw_e5", pb_if.sw_db, 2'h3);
    check("t1_press_e5", pb_if.btn_press, 4'hf);
    check("t1_valid_e5", pb_if.mode_valid, 0);
    tick(1);
    check("t1_press_e6", pb_if.btn_press, 4'h0);
    check("t1_mode_e6", pb_if.mode, 3);
    check("t1_valid_e6", pb_if.mode_valid, 1);
    tick(1);
    check("t1_valid_e7", pb_if.mode_valid, 0);
    pb_if.btn = 4'b0000;
    pb_if.sw  = 2'b00;
    tick(6);
    check("t1_rel_db", pb_if.btn_db, 0);
    check("t1_rel_sw", pb_if.sw_db, 0);
    check("t1_rel_press", pb_if.btn_press, 0);
    check("t1_rel_mode", pb_if.mode, 3);
    tick(2);

    // 2. clean press and release of btn[1]
    pb_if.btn = 4'b0010;
    tick(5);
    check("t2_db_e4", pb_if.btn_db, 4'h0);
    tick(1);
    check("t2_db_e5", pb_if.btn_db, 4'h2);
    check("t2_press_e5", pb_if.btn_press, 4'h2);
    tick(1);
    check("t2_press_e6", pb_if.btn_press, 4'h0);
    check("t2_mode_e6", pb_if.mode, 1);
    check("t2_valid_e6", pb_if.mode_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t2_hold_press", pb_if.btn_press, 0);
      check("t2_hold_valid", pb_if.mode_valid, 0);
    end
    pb_if.btn = 4'b0000;
    tick(5);
    check("t2_rel_e4", pb_if.btn_db, 4'h2);
    tick(1);
    check("t2_rel_e5", pb_if.btn_db, 4'h0);
    check("t2_rel_press", pb_if.btn_press, 0);
    tick(1);
    check("t2_rel_mode", pb_if.mode, 1);
    check("t2_rel_valid", pb_if.mode_valid, 0);

    // 3. glitch on btn[2]: 3 high, 1 low, 3 high
    pb_if.btn = 4'b0100;
    tick(3);
    pb_if.btn = 4'b0000;
    tick(1);
    pb_if.btn = 4'b0100;
    tick(3);
    pb_if.btn = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("t3_glitch_db", pb_if.btn_db, 0);
      check("t3_glitch_press", pb_if.btn_press, 0);
      check("t3_glitch_valid", pb_if.mode_valid, 0);
    end
    pb_if.btn = 4'b0100;
    tick(6);
    check("t3_acc_db", pb_if.btn_db, 4'h4);
    check("t3_acc_press", pb_if.btn_press, 4'h4);
    tick(1);
    check("t3_acc_mode", pb_if.mode, 2);
    check("t3_acc_valid", pb_if.mode_valid, 1);
    pb_if.btn = 4'b0000;
    tick(8);

    // 4. btn[0] and btn[3] together, then drop btn[3]
    pb_if.btn = 4'b1001;
    tick(6);
    check("t4_press", pb_if.btn_press, 4'h9);
    check("t4_db", pb_if.btn_db, 4'h9);
    tick(1);
    check("t4_mode", pb_if.mode, 3);
    check("t4_valid", pb_if.mode_valid, 1);
    tick(1);
    check("t4_valid_once", pb_if.mode_valid, 0);
    pb_if.btn = 4'b0001;
    tick(8);
    check("t4_hold_db", pb_if.btn_db, 4'h1);
    check("t4_hold_mode", pb_if.mode, 3);
    check("t4_hold_valid", pb_if.mode_valid, 0);
    pb_if.btn = 4'b0000;
    tick(8);

    // 5. switch debounce, then short low glitch
    pb_if.sw = 2'b01;
    tick(5);
    check("t5_sw_e4", pb_if.sw_db, 0);
    tick(1);
    check("t5_sw_e5", pb_if.sw_db, 1);
    check("t5_press", pb_if.btn_press, 0);
    tick(1);
    check("t5_mode", pb_if.mode, 3);
    check("t5_valid", pb_if.mode_valid, 0);
    pb_if.sw = 2'b00;
    tick(2);
    pb_if.sw = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("t5_glitch_sw", pb_if.sw_db, 1);
    end
    pb_if.sw = 2'b00;
    tick(8);

    // 6. reset lands mid-qualification of btn[3]
    pb_if.btn = 4'b1000;
    tick(3);
    sys_rst = 1'b1;
    tick(1);
    check("t6_rst_mode", pb_if.mode, 0);
    check("t6_rst_db", pb_if.btn_db, 0);
    sys_rst = 1'b0;
    tick(5);
    check("t6_db_e4", pb_if.btn_db, 0);
    check("t6_press_e4", pb_if.btn_press, 0);
    tick(1);
    check("t6_db_e5", pb_if.btn_db, 4'h8);
    check("t6_press_e5", pb_if.btn_press, 4'h8);
    check("t6_mode_e5", pb_if.mode, 0);
    tick(1);
    check("t6_mode_e6", pb_if.mode, 3);
    check("t6_valid_e6", pb_if.mode_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pb_input_cond.md
Name: pb_input_cond

Overview:
- Input-side front end for the board's push buttons and slide switches.
- Synchronises each raw pin to clk_125, debounces it, and produces clean levels plus one-cycle press pulses.
- Encodes button presses into a registered 2-bit mode with a valid strobe.
- Feeds the mode/LED datapath, which thereafter consumes mode and sw_db instead of raw pins.

Parameters:
- N_BTN, 4, number of push-button inputs; the mode encoder is defined for exactly 4.
- N_SW, 2, number of slide-switch inputs.
- DEBOUNCE_CYCLES, 1250000, consecutive cycles a new level must hold before it is accepted (10 ms at 125 MHz); legal range is 2 or more.
- CNT_W, 21, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk_125  in  1  125 MHz system clock, the only clock.
- sys_rst  in  1  synchronous, active-high reset.
- btn  in  N_BTN  raw push buttons, active-high, asynchronous to clk_125.
- sw  in  N_SW  raw slide switches, asynchronous to clk_125.
- btn_db  out  N_BTN  debounced button levels.
- sw_db  out  N_SW  debounced switch levels.
- btn_press  out  N_BTN  one-cycle pulse on each debounced 0->1 button edge.
- mode  out  2  latched mode (0..3).
- mode_valid  out  1  one-cycle strobe, high in the first cycle a new mode value is presented.

Behaviour:
- Reset: sys_rst is sampled on posedge clk_125 only. On reset, clear both synchroniser stages, every debounce counter and stable register, btn_db, sw_db, btn_press, mode and mode_valid to 0. Reset asserted mid-count discards the partial count. After release, inputs that are already high must be re-qualified for the full DEBOUNCE_CYCLES.
- Synchroniser: every btn and sw bit passes through a two-flop chain (s1, then s2). Only s2 is used downstream.
- Debouncer: identical and independent for each of the N_BTN+N_SW bits, each with its own stable bit and cnt.
  - If s2 == stable, cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1, stable <= s2 and cnt <= 0.
  - Else cnt <= cnt+1.
  - Any cycle where s2 returns to stable restarts qualification from 0, so glitches shorter than DEBOUNCE_CYCLES never change stable. Rising and falling edges are qualified symmetrically.
- Debounced outputs: btn_db and sw_db are the stable registers.
- Latency: the raw level is first sampled into s1 at edge 0, and stable changes at edge DEBOUNCE_CYCLES+1.
- btn_press[i]: registered. It is 1 for exactly the cycle following the edge on which stable[i] goes 0->1, so it coincides with the first high cycle of btn_db[i]. A 1->0 transition produces no pulse.
- Mode encoder: on each edge, if any btn_press bit is set, mode <= index of the highest set bit (priority btn3 > btn2 > btn1 > btn0) and mode_valid <= 1. Otherwise mode holds and mode_valid <= 0.
  - mode therefore updates one cycle after btn_press.
  - Pressing the button of the current mode still pulses mode_valid, with mode unchanged.
- Held buttons: a button held indefinitely gives one btn_press and one mode_valid. Releasing a higher-priority button while a lower one stays held does not change mode.
- Width rules: cnt is unsigned CNT_W bits and never wraps, because it is capped at DEBOUNCE_CYCLES-1.
- No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
1. Reset behaviour: hold sys_rst for 3 cycles with btn=4'b1111 and sw=2'b11 -> all outputs stay 0 during reset. After release, btn_db=1111 and sw_db=11 at edge 5 after release. btn_press=1111 for one cycle, then mode=3 with mode_valid=1 for one cycle.
2. Clean press: raise btn[1] at edge 0 and hold -> btn_db[1] goes high at edge 5, btn_press[1] is high for one cycle only, and at edge 6 mode=1 with a single mode_valid pulse. Release btn[1] -> btn_db[1] falls at edge 5 after the release, with no pulse and mode stays 1.
3. Glitch rejection: pulse btn[2] high for 3 cycles, low for 1, then high for 3 -> btn_db[2] never rises and no pulses occur. Then hold btn[2] for 4 or more cycles -> accepted, and mode=2.
4. Simultaneous press: raise btn[0] and btn[3] on the same edge -> both btn_press bits pulse together, and mode=3 with one mode_valid.
5. Switch debounce: toggle sw[0] 0->1 and hold, with btn idle -> sw_db[0] goes high at edge 5, and mode and mode_valid are unaffected. Then a 2-cycle low glitch on sw[0] -> sw_db[0] stays 1.
6. Reset mid-qualification: raise btn[3] and assert sys_rst at edge 3 for 1 cycle -> no press is seen. btn_db[3] rises only at edge 5 after reset release, and mode returns from 0 to 3 at the following edge.
